// File: rtl/cacheline_mem_arbiter.sv
// cacheline_mem_arbiter
// Shares one cacheline-adaptor memory port between the i-cache (read only)
// and the d-cache (read/write). The d-cache has fixed priority. A starvation
// counter forces an i-cache grant after STARVE_MAX consecutive d-grants that
// were taken while the i-cache was waiting.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_read/i_address          i-cache line read request
//   i_rdata/i_resp            i-cache response (valid only while i_resp=1)
//   d_read/d_write/d_address  d-cache line request
//   d_wdata                   d-cache writeback line
//   d_rdata/d_resp            d-cache response (valid only while d_resp=1)
//   mem_read/mem_write        adaptor request, driven from latched state only
//   mem_address/mem_wdata     adaptor address and write line
//   mem_rdata/mem_resp        adaptor read line and 1-cycle completion
//   grant_owner               00 none, 01 i-cache, 10 d-cache
//   arb_busy                  high whenever the arbiter is not idle
module cacheline_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 256,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [1:0]        grant_owner,
    output logic              arb_busy
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              op_write_q, op_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [1:0]        grant_owner_q, grant_owner_d;
    logic              arb_busy_q, arb_busy_d;
    logic              d_req;

    assign d_req = d_read | d_write;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_write_d   = op_write_q;
        case (state_q)
            IDLE: begin
                if (i_read && starve_cnt_q == STARVE_LIM) begin
                    // i-cache has waited through STARVE_MAX d-grants
                    state_d      = GRANT_I;
                    addr_d       = i_address;
                    op_write_d   = 1'b0;
                    starve_cnt_d = '0;
                end else if (d_req) begin
                    state_d    = GRANT_D;
                    addr_d     = d_address;
                    // read+write together is illegal; treat it as a write
                    op_write_d = d_write;
                    if (d_write) wdata_d = d_wdata;
                    if (i_read && starve_cnt_q != STARVE_LIM)
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                end else if (i_read) begin
                    state_d      = GRANT_I;
                    addr_d       = i_address;
                    op_write_d   = 1'b0;
                    starve_cnt_d = '0;
                end
            end
            GRANT_I, GRANT_D: if (mem_resp) state_d = DONE;
            default:          state_d = IDLE;  // DONE: one quiet cycle
        endcase

        // Outputs are decoded from next state so they come straight off flops.
        mem_read_d    = (state_d == GRANT_I || state_d == GRANT_D) && !op_write_d;
        mem_write_d   = (state_d == GRANT_I || state_d == GRANT_D) && op_write_d;
        grant_owner_d = (state_d == GRANT_I) ? 2'b01 :
                        (state_d == GRANT_D) ? 2'b10 : 2'b00;
        arb_busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            starve_cnt_q  <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            op_write_q    <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            grant_owner_q <= 2'b00;
            arb_busy_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            op_write_q    <= op_write_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            grant_owner_q <= grant_owner_d;
            arb_busy_q    <= arb_busy_d;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign grant_owner = grant_owner_q;
    assign arb_busy    = arb_busy_q;

    // Response is steered to the owner only. A transaction abandoned by reset
    // must not complete, so rst masks the response in its own cycle.
    assign i_resp  = (state_q == GRANT_I) && mem_resp && !rst;
    assign d_resp  = (state_q == GRANT_D) && mem_resp && !rst;
    assign i_rdata = i_resp ? mem_rdata : '0;
    assign d_rdata = d_resp ? mem_rdata : '0;

endmodule
